pipo_pipeline: RTL
==================

PIPO_PIPELINE -- requirements
Module: pipo_pipeline

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  WIDTH  upstream data word.
REQ-006 SHALL have port in_valid  input  1  upstream word present.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  WIDTH  data of last stage.
REQ-009 SHALL have port out_valid  output  1  last stage holds a word.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port fill_count  output  $clog2(DEPTH+1)  number of occupied stages.
REQ-012 SHALL have port flush  input  1  synchronous discard of all stages (present only with PIPO_PIPE_FLUSH_EN).

Function
REQ-013 Stage k (0..DEPTH-1) SHALL hold data_k and valid_k; stage 0 fed by input, stage DEPTH-1 drives out_data/out_valid.
REQ-014 Transfer SHALL occur at input when in_valid&&in_ready, at output when out_valid&&out_ready.
REQ-015 ready_k SHALL equal !valid_k || ready_(k+1); ready_DEPTH = out_ready; in_ready = ready_0 (bubbles collapse, combinational ready chain).
REQ-016 When ready_k is 1, stage k SHALL load data/valid of stage k-1 (stage 0: in_data/in_valid) on the next edge; otherwise it holds.
REQ-017 data_k SHALL load only when the incoming valid is 1; bubbles SHALL NOT overwrite data.
REQ-018 Latency SHALL be DEPTH cycles from input transfer to out_valid with out_ready held 1; throughput one word/cycle.
REQ-019 out_data SHALL stay stable while out_valid&&!out_ready.
REQ-020 Full (all valid_k=1) with out_ready=0: in_ready SHALL be 0, no stage changes.
REQ-021 Full with out_ready=1: simultaneous input and output transfer SHALL be allowed in the same cycle, fill_count unchanged.
REQ-022 Empty: out_valid SHALL be 0, in_ready SHALL be 1.
REQ-023 fill_count SHALL be the registered population count of valid_k, consistent with valid bits every cycle.
REQ-024 No word SHALL be dropped, duplicated or reordered.

Reset
REQ-025 rst low SHALL immediately clear all valid_k and data_k to 0, regardless of clk.
REQ-026 During reset: out_valid=0, out_data=0, fill_count=0; in_ready SHALL be 0 while rst is low.
REQ-027 Reset mid-transfer SHALL discard all held words; first edge after rst release SHALL accept input normally.

Configuration
REQ-028 Macro PIPO_PIPE_FLUSH_EN defined: flush port exists; flush=1 forces in_ready=0 and out_valid=0 combinationally and clears all valid_k at the next edge; data_k retained; flush overrides all transfers.
REQ-029 Macro undefined: no flush port; behaviour identical to flush tied 0.

Structure
REQ-030 Shared package blowfish_pkg SHALL hold BF_HALF_W=32 (WIDTH default) and the count-width helper constant/function.
REQ-031 One sub-module pipo_stage (one data+valid register slice with load control) SHALL be instantiated DEPTH times via generate.

Verification (WIDTH=32, DEPTH=3)
REQ-032 Stream 0x00000001..0x00000005 back-to-back, out_ready=1 -> first out_valid 3 cycles after first accept, outputs in order, one per cycle.
REQ-033 Push 3 words, out_ready=0 -> fill_count=3, in_ready=0, out_data=0x00000001 held stable 5 cycles.
REQ-034 Full, then in_valid=1 and out_ready=1 for 4 cycles with 0xA0..0xA3 -> one in, one out per cycle, fill_count stays 3.
REQ-035 Push 0xDEADBEEF, drop rst low between edges mid-pipe -> out_valid=0, fill_count=0, out_data=0 immediately; post-release 0x12345678 emerges after 3 cycles.
REQ-036 With PIPO_PIPE_FLUSH_EN, 2 words held, pulse flush 1 cycle -> in_ready=0 and out_valid=0 that cycle, fill_count=0 next cycle, no stale word ever emitted.

Source files
------------

// File: rtl/blowfish_pkg.sv
// Shared constants for the pipeline slice: default data width and the
// helper that sizes the occupancy counter for a given stage count.
package blowfish_pkg;

   localparam int BF_HALF_W = 32;

   // Bits needed to count 0..depth occupied stages inclusive.
   function automatic int cnt_w(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipo_pipeline_stage.sv
// One data+valid register slice. It takes the upstream word when load is set,
// and a clear drops the valid bit while keeping the data.
module pipo_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d_in,
   input  logic             v_in,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             valid_next
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   // A bubble moves down the pipe as a cleared valid bit and leaves the data alone.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = v_in;
         if (v_in) begin
            data_d = d_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data       = data_q;
   assign valid      = valid_q;
   assign valid_next = valid_d;

endmodule

// File: rtl/pipo_pipeline.sv
// Valid/ready register pipeline. Bubbles collapse through a combinational ready chain.
// The optional synchronous flush port is enabled with `define PIPO_PIPE_FLUSH_EN.
module pipo_pipeline
   import blowfish_pkg::*;
#(
   parameter int WIDTH = BF_HALF_W,
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [cnt_w(DEPTH)-1:0]   fill_count
`ifdef PIPO_PIPE_FLUSH_EN
   ,
   input  logic                      flush
`endif
);

   localparam int CW = cnt_w(DEPTH);

   logic                        flush_i;
   logic [DEPTH:0]              ready;
   logic [DEPTH-1:0]            valid;
   logic [DEPTH-1:0]            valid_nxt;
   logic [DEPTH-1:0]            src_valid;
   logic [DEPTH-1:0][WIDTH-1:0] data;
   logic [DEPTH-1:0][WIDTH-1:0] src_data;
   logic [CW-1:0]               fill_count_q, fill_count_d;

`ifdef PIPO_PIPE_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   // A stage can take a word if it is empty or if its own word moves on this cycle.
   always_comb begin
      ready        = '0;
      ready[DEPTH] = out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         ready[k] = !valid[k] || ready[k+1];
      end
   end

   always_comb begin
      src_data     = '0;
      src_valid    = '0;
      src_data[0]  = in_data;
      src_valid[0] = in_valid;
      for (int k = 1; k < DEPTH; k++) begin
         src_data[k]  = data[k-1];
         src_valid[k] = valid[k-1];
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      pipo_stage #(.WIDTH(WIDTH)) u_stage (
         .clk        (clk),
         .rst        (rst),
         .load       (ready[k]),
         .clear      (flush_i),
         .d_in       (src_data[k]),
         .v_in       (src_valid[k]),
         .data       (data[k]),
         .valid      (valid[k]),
         .valid_next (valid_nxt[k])
      );
   end

   // The count tracks the next valid vector so it registers together with the stages.
   always_comb begin
      fill_count_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fill_count_d = fill_count_d + CW'(valid_nxt[k]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill_count_q <= '0;
      end else begin
         fill_count_q <= fill_count_d;
      end
   end

   assign in_ready   = ready[0] && rst && !flush_i;
   assign out_valid  = valid[DEPTH-1] && !flush_i;
   assign out_data   = data[DEPTH-1];
   assign fill_count = fill_count_q;

endmodule
